// File: rtl/mem_access_unit.sv
// Data-memory access stage: owns a word-organised synchronous RAM and performs
// byte/half/word loads and stores at any byte address. Accesses that cross a
// word boundary take two RAM cycles. Load data is right-aligned, zero-filled.
module mem_access_unit #(
  parameter int CPU_WORD       = 32,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic [CPU_WORD-1:0] addr,
  input  logic [CPU_WORD-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                rvalid,
  output logic [CPU_WORD-1:0] rdata
);

  localparam int DEPTH = 2 ** RAM_ADDR_WIDTH;
  localparam int NB    = CPU_WORD / 8;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_RESP} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_we;
  logic [1:0]                r_size;
  logic [RAM_ADDR_WIDTH-1:0] r_widx;
  logic [1:0]                r_off;
  logic [CPU_WORD-1:0]       r_wdata;
  logic [CPU_WORD-1:0]       r_lowbuf;
  logic [CPU_WORD-1:0]       r_rdata;

  logic [CPU_WORD-1:0]       r_mem [DEPTH];
  logic [CPU_WORD-1:0]       r_ram_q;

  logic [2:0]                w_nbytes;
  logic                      w_split;
  logic [NB-1:0]             w_size_be;
  logic [CPU_WORD-1:0]       w_size_dmask;
  logic [2*NB-1:0]           w_lane_mask;
  logic [2*CPU_WORD-1:0]     w_wide_wdata;
  logic [2*CPU_WORD-1:0]     w_rd_wide;
  logic [2*CPU_WORD-1:0]     w_rd_shift;
  logic [CPU_WORD-1:0]       w_rd_aligned;

  logic                      w_ram_we;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
  logic [NB-1:0]             w_ram_be;
  logic [CPU_WORD-1:0]       w_ram_wd;

  logic                      w_unused_bits;

  // Upper address bits and the discarded half of the read shifter are don't-care.
  assign w_unused_bits = ^{addr[CPU_WORD-1:RAM_ADDR_WIDTH+2], w_rd_shift[2*CPU_WORD-1:CPU_WORD]};

  // Decode the latched size into byte count, lane mask and data mask; detect a split.
  always_comb begin
    w_nbytes     = 3'd4;
    w_size_be    = '1;
    w_size_dmask = '1;
    case (r_size)
      2'b00: begin
        w_nbytes     = 3'd1;
        w_size_be    = {{(NB-1){1'b0}}, 1'b1};
        w_size_dmask = {{(CPU_WORD-8){1'b0}}, 8'hFF};
      end
      2'b01: begin
        w_nbytes     = 3'd2;
        w_size_be    = {{(NB-2){1'b0}}, 2'b11};
        w_size_dmask = {{(CPU_WORD-16){1'b0}}, 16'hFFFF};
      end
      default: ;
    endcase
    w_split      = ({1'b0, r_off} + w_nbytes) > 3'd4;
    w_lane_mask  = {{NB{1'b0}}, w_size_be} << r_off;
    w_wide_wdata = {{CPU_WORD{1'b0}}, r_wdata} << {r_off, 3'b000};
  end

  // Steer the RAM port: word W in FIRST, word W+1 (wrapping) in SECOND.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = r_widx;
    w_ram_be   = w_lane_mask[NB-1:0];
    w_ram_wd   = w_wide_wdata[CPU_WORD-1:0];
    if (r_state == S_FIRST) begin
      w_ram_we = r_we;
    end else if (r_state == S_SECOND) begin
      w_ram_we   = r_we;
      w_ram_addr = r_widx + 1'b1;
      w_ram_be   = w_lane_mask[2*NB-1:NB];
      w_ram_wd   = w_wide_wdata[2*CPU_WORD-1:CPU_WORD];
    end
  end

  // Byte-enabled synchronous RAM with a registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_ram_be[b]) r_mem[w_ram_addr][8*b +: 8] <= w_ram_wd[8*b +: 8];
      end
    end
    r_ram_q <= r_mem[w_ram_addr];
  end

  // Assemble load bytes from the low buffer and current RAM output starting at the offset.
  always_comb begin
    w_rd_wide    = w_split ? {r_ram_q, r_lowbuf} : {{CPU_WORD{1'b0}}, r_ram_q};
    w_rd_shift   = w_rd_wide >> {r_off, 3'b000};
    w_rd_aligned = w_rd_shift[CPU_WORD-1:0] & w_size_dmask;
  end

  // State register, request latch, low-word buffer and held load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_widx   <= '0;
      r_off    <= 2'b00;
      r_wdata  <= '0;
      r_lowbuf <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req) begin
        r_we    <= we;
        r_size  <= size;
        r_widx  <= addr[RAM_ADDR_WIDTH+1:2];
        r_off   <= addr[1:0];
        r_wdata <= wdata;
      end
      if (r_state == S_SECOND) r_lowbuf <= r_ram_q;
      if (r_state == S_RESP)   r_rdata  <= w_rd_aligned;
    end
  end

  // Next-state and completion strobes.
  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    rvalid = 1'b0;
    case (r_state)
      S_IDLE: if (req) w_next = S_FIRST;
      S_FIRST: begin
        if (w_split) begin
          w_next = S_SECOND;
        end else if (r_we) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      S_SECOND: begin
        if (r_we) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        done   = 1'b1;
        rvalid = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  // The assembled word is visible during RESP and held from the register afterwards.
  assign rdata = (r_state == S_RESP) ? w_rd_aligned : r_rdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage feeding the load-extend stage, which sign/zero-extends loaded data.
- Owns a word-organised synchronous RAM and performs byte, half and word stores and loads at any byte address.
- Accesses that straddle a word boundary are split into two RAM cycles.
- Load data is returned right-aligned to bit 0 and zero-filled above the access size. Sign extension is done downstream.

Parameters:
CPU_WORD  32  data/address width in bits
RAM_ADDR_WIDTH  10  word-index bits; RAM depth = 2**RAM_ADDR_WIDTH words of CPU_WORD bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  access request; sampled only when busy=0
we  in  1  1=store, 0=load; sampled with req
size  in  2  00=byte, 01=half, 10=word, 11=treated as word
addr  in  CPU_WORD  byte address; little-endian
wdata  in  CPU_WORD  store data; low 8/16/32 bits used per size
busy  out  1  high whenever FSM not IDLE
done  out  1  one-cycle pulse when the access completes
rvalid  out  1  one-cycle pulse, loads only, coincident with done
rdata  out  CPU_WORD  load result; held until next load's rvalid

Behaviour:
- Reset, async: FSM to IDLE; busy=0, done=0, rvalid=0, rdata=0; internal latches cleared. RAM contents are not cleared.
- Reset mid-access: abandons the access immediately. A first-word write already performed stays; the second-word write is not performed.
- Request acceptance:
  - Cycle N, IDLE with req=1: latch we, size, addr, wdata. Next state FIRST.
  - req while busy=1 is ignored; the requester holds req until busy=0.
- Address decode:
  - Word index W = addr[RAM_ADDR_WIDTH+1:2]; upper address bits are ignored.
  - Byte offset o = addr[1:0].
- Split rule: split when o + bytes(size) > 4, i.e. half at o=3, or word at o=1..3. Bytes never split.
- Second word index is W+1 modulo depth: last word wraps to word 0.
- RAM: synchronous write with per-lane byte enables; synchronous read with address in cycle k and data in cycle k+1.
- FSM states IDLE, FIRST, SECOND, RESP:
  - FIRST (N+1): present W.
    - Store: write the lanes o..min(o+n-1,3) from the low wdata bytes in order. If no split, done=1 and go to IDLE; else go to SECOND.
    - Load: go to SECOND if split, else RESP.
  - SECOND (N+2): capture the word-W read data into a low buffer, then present W+1.
    - Store: write the remaining bytes into lanes 0.. of W+1; done=1; go to IDLE.
    - Load: go to RESP.
  - RESP: assemble bytes starting at offset o across the buffered word and the current RAM output. Register into rdata, zero-filled above the size, and assert rvalid=1 and done=1 for this cycle. Go to IDLE.
- Latency:
  - Aligned or non-split store: done at N+1.
  - Split store: done at N+2.
  - Non-split load: rvalid at N+2.
  - Split load: rvalid at N+3.
- Back-to-back: a new req may be presented in the cycle busy returns to 0. It is accepted that cycle; there is no bubble beyond the FSM.
- rdata changes only in RESP. Stores never alter rdata.
- Unwritten lanes are never modified. A store with size=11 behaves exactly as size=10.

Test Plan:
- Store word 0x11223344 at addr 0x0, then load word at 0x0 -> store done at N+1; load rvalid at N+2 with rdata=0x11223344.
- Store byte 0xAB at addr 0x5 over a word preloaded with 0xFFFFFFFF, then load word 0x4 -> rdata=0xFFFFABFF; load byte at 0x5 returns rdata=0x000000AB.
- Store half 0xBEEF at addr 0x3 (split):
  - done at N+2.
  - Word 0 lane 3=0xEF and word 1 lane 0=0xBE, all other lanes unchanged.
  - Load half at 0x3 -> rvalid at N+3, rdata=0x0000BEEF.
- Store word 0xCAFEF00D at addr (depth*4-2), wrap case -> last word lanes 2,3=0x0D,0xF0 and word 0 lanes 0,1=0xFE,0xCA; load back returns 0xCAFEF00D.
- Assert rst during SECOND of a split store -> busy, done and rvalid at 0 immediately; the first-word lane is written, the second word is unchanged; a subsequent aligned load behaves normally.
- Hold req=1 continuously with two different loads -> the second is accepted only when busy=0; rdata is stable between rvalid pulses.
